// File: rtl/sdf_ntt_pkg.sv
// rtl/sdf_ntt_pkg.sv - shared stage geometry helpers and idle select defaults for the SDF NTT sequencer
package sdf_ntt_pkg;

  // Selects driven by a stage outside its window: pass the buffer through, reload it from input
  localparam logic IDLE_OUT_SEL = 1'b0;
  localparam logic IDLE_IN_SEL  = 1'b1;

  function automatic int stage_delay(input int s, input int n);
    return n >> (s + 1);
  endfunction

  function automatic int stage_offset(input int s, input int n);
    return n - 2 * stage_delay(s, n);
  endfunction

endpackage

// File: rtl/sdf_stage_ctl.sv
// rtl/sdf_stage_ctl.sv - per-stage window phase counter, buffer mux selects and twiddle index
module sdf_stage_ctl
  import sdf_ntt_pkg::*;
#(
  parameter int S = 0,
  parameter int N = 8,
  localparam int LOG_N = $clog2(N),
  localparam int TW_W  = LOG_N - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            head,
  output logic            out_sel,
  output logic            in_sel,
  output logic [TW_W-1:0] tw_idx
);

  localparam int D       = stage_delay(S, N);
  localparam int SEL_BIT = $clog2(D);

  logic             active;
  logic [LOG_N-1:0] phase;

  // Phase 0 is the head cycle itself; it decodes to the idle selects, so the counter starts at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      phase  <= '0;
    end else if (head) begin
      active <= 1'b1;
      phase  <= LOG_N'(1);
    end else if (active) begin
      phase  <= phase + LOG_N'(1);
      active <= (phase != LOG_N'(N - 1));
    end
  end

  assign out_sel = active ? phase[SEL_BIT]  : IDLE_OUT_SEL;
  assign in_sel  = active ? ~phase[SEL_BIT] : IDLE_IN_SEL;

  if (S == 0) begin : g_tw0
    assign tw_idx = '0;
  end else begin : g_tw
    logic             tw_act;
    logic [LOG_N-1:0] tw_cnt;

    // Twiddle window lags the stage window by D and may run past it by D cycles
    always_ff @(posedge clk) begin
      if (rst) begin
        tw_act <= 1'b0;
        tw_cnt <= '0;
      end else if (active && (phase == LOG_N'(D))) begin
        tw_act <= 1'b1;
        tw_cnt <= LOG_N'(1);
      end else if (tw_act) begin
        tw_cnt <= tw_cnt + LOG_N'(1);
        tw_act <= (tw_cnt != LOG_N'(N - 1));
      end
    end

    assign tw_idx = tw_act ? TW_W'(tw_cnt >> (LOG_N - S)) : '0;
  end

endmodule

// File: rtl/sdf_ntt_sequencer.sv
// rtl/sdf_ntt_sequencer.sv - SDF NTT stream sequencer top; SDF_PROTO_CHECK_EN enables the in_valid gap checker
module sdf_ntt_sequencer
  import sdf_ntt_pkg::*;
#(
  parameter int N = 8,
  localparam int LOG_N = $clog2(N),
  localparam int TW_W  = LOG_N - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic [LOG_N-1:0]      buf_out_sel,
  output logic [LOG_N-1:0]      buf_in_sel,
  output logic [LOG_N*TW_W-1:0] tw_idx,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  done_tick,
  output logic                  busy,
  output logic                  err
);

  logic [LOG_N-1:0] beat_left;
  logic             frame_start;
  logic [N-2:0]     head_dl;
  logic             out_act;
  logic [LOG_N-1:0] out_cnt;

  // A frame owns the next N cycles regardless of in_valid; bubbles count as beats
  assign frame_start = in_valid && (beat_left == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_left <= '0;
      head_dl   <= '0;
    end else begin
      if (frame_start) begin
        beat_left <= LOG_N'(N - 1);
      end else if (beat_left != '0) begin
        beat_left <= beat_left - LOG_N'(1);
      end
      head_dl <= {head_dl[N-3:0], frame_start};
    end
  end

  for (genvar s = 0; s < LOG_N; s++) begin : g_stage
    logic head;
    if (s == 0) begin : g_head0
      assign head = frame_start;
    end else begin : g_headn
      assign head = head_dl[stage_offset(s, N) - 1];
    end

    sdf_stage_ctl #(
      .S(s),
      .N(N)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .head    (head),
      .out_sel (buf_out_sel[s]),
      .in_sel  (buf_in_sel[s]),
      .tw_idx  (tw_idx[s*TW_W +: TW_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_act <= 1'b0;
      out_cnt <= '0;
    end else if (head_dl[N-2]) begin
      out_act <= 1'b1;
      out_cnt <= LOG_N'(1);
    end else if (out_act) begin
      out_cnt <= out_cnt + LOG_N'(1);
      out_act <= (out_cnt != LOG_N'(N - 1));
    end
  end

  assign out_sof   = head_dl[N-2];
  assign out_valid = out_sof | out_act;
  assign done_tick = out_act && (out_cnt == LOG_N'(N - 1));
  // Built only from registers, so busy rises the cycle after the first beat is seen
  assign busy      = (beat_left != '0) || (|head_dl) || out_act;

`ifdef SDF_PROTO_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((beat_left != '0) && !in_valid) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_ntt_sequencer.sv
// tb/tb_sdf_ntt_sequencer.sv - directed self-checking bench for sdf_ntt_sequencer (N=8 and N=16, SDF_PROTO_CHECK_EN aware)
module tb_sdf_ntt_sequencer;

  localparam int LEN = 212;

  logic clk;
  logic rst;
  logic in_valid;

  logic [2:0]  bos8, bis8;
  logic [5:0]  tw8;
  logic        ov8, sof8, dn8, bz8, er8;
  logic [3:0]  bos16, bis16;
  logic [11:0] tw16;
  logic        ov16, sof16, dn16, bz16, er16;

  sdf_ntt_sequencer #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .buf_out_sel(bos8), .buf_in_sel(bis8), .tw_idx(tw8),
    .out_valid(ov8), .out_sof(sof8), .done_tick(dn8), .busy(bz8), .err(er8)
  );

  sdf_ntt_sequencer #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .buf_out_sel(bos16), .buf_in_sel(bis16), .tw_idx(tw16),
    .out_valid(ov16), .out_sof(sof16), .done_tick(dn16), .busy(bz16), .err(er16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int t0s [2][32];
  int nfr [2];
  int nxt [2];
  bit errx[2];
  bit live[2];

  bit vr[LEN];
  bit vv[LEN];
  int ln = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs straight from the window/phase arithmetic for every frame since last reset
  task automatic expect_at(input int m, input int c, output int bos, output int tw,
                           output bit ov, output bit sof, output bit dn, output bit bz);
    int n, lg, tww, t0, o, d, p, j;
    n = (m == 0) ? 8 : 16;
    lg = (m == 0) ? 3 : 4;
    tww = lg - 1;
    bos = 0; tw = 0; ov = 0; sof = 0; dn = 0; bz = 0;
    for (int f = 0; f < nfr[m]; f++) begin
      t0 = t0s[m][f];
      o = 0;
      for (int s = 0; s < lg; s++) begin
        d = n >> (s + 1);
        p = c - (t0 + o);
        if (p >= 0 && p < n && ((p / d) % 2) == 1) bos |= (1 << s);
        j = p - d;
        if (s >= 1 && j >= 0 && j < n) tw |= (j >> (lg - s)) << (s * tww);
        o += d;
      end
      if (c >= t0 + n - 1 && c <= t0 + 2*n - 2) ov = 1;
      if (c == t0 + n - 1) sof = 1;
      if (c == t0 + 2*n - 2) dn = 1;
      if (c >= t0 + 1 && c <= t0 + 2*n - 2) bz = 1;
    end
  endtask

  task automatic check_dut(input int m);
    int eb, et, lg;
    bit eo, es, ed, ez;
    string p;
    expect_at(m, cyc, eb, et, eo, es, ed, ez);
    lg = (m == 0) ? 3 : 4;
    p = (m == 0) ? "n8" : "n16";
    chk({p, ".buf_out_sel"}, (m == 0) ? int'(bos8) : int'(bos16), eb);
    chk({p, ".buf_in_sel"},  (m == 0) ? int'(bis8) : int'(bis16), (~eb) & ((1 << lg) - 1));
    chk({p, ".tw_idx"},      (m == 0) ? int'(tw8)  : int'(tw16),  et);
    chk({p, ".out_valid"},   (m == 0) ? int'(ov8)  : int'(ov16),  int'(eo));
    chk({p, ".out_sof"},     (m == 0) ? int'(sof8) : int'(sof16), int'(es));
    chk({p, ".done_tick"},   (m == 0) ? int'(dn8)  : int'(dn16),  int'(ed));
    chk({p, ".busy"},        (m == 0) ? int'(bz8)  : int'(bz16),  int'(ez));
    chk({p, ".err"},         (m == 0) ? int'(er8)  : int'(er16),  int'(errx[m]));
  endtask

  task automatic model_step(input int m);
    int n;
    n = (m == 0) ? 8 : 16;
    if (rst) begin
      nfr[m] = 0; nxt[m] = 0; errx[m] = 0; live[m] = 1;
    end else begin
`ifdef SDF_PROTO_CHECK_EN
      if (nfr[m] > 0 && !in_valid && cyc > t0s[m][nfr[m]-1] && cyc < t0s[m][nfr[m]-1] + n)
        errx[m] = 1;
`endif
      if (in_valid && cyc >= nxt[m]) begin
        t0s[m][nfr[m]] = cyc;
        nfr[m]++;
        nxt[m] = cyc + n;
      end
    end
  endtask

  // Hand-computed literal: pins both the model and the DUT. sel 0 bos,1 tw,2 ov,3 sof,4 done,5 busy,6 bos[3],7 err
  task automatic lit(input int m, input string nm, input int sel, input int want);
    int eb, et, mv, dv;
    bit eo, es, ed, ez;
    expect_at(m, cyc, eb, et, eo, es, ed, ez);
    case (sel)
      0: begin mv = eb;          dv = (m == 0) ? int'(bos8) : int'(bos16); end
      1: begin mv = et;          dv = (m == 0) ? int'(tw8)  : int'(tw16);  end
      2: begin mv = int'(eo);    dv = (m == 0) ? int'(ov8)  : int'(ov16);  end
      3: begin mv = int'(es);    dv = (m == 0) ? int'(sof8) : int'(sof16); end
      4: begin mv = int'(ed);    dv = (m == 0) ? int'(dn8)  : int'(dn16);  end
      5: begin mv = int'(ez);    dv = (m == 0) ? int'(bz8)  : int'(bz16);  end
      6: begin mv = (eb >> 3) & 1; dv = int'(bos16[3]); end
      default: begin mv = int'(errx[m]); dv = (m == 0) ? int'(er8) : int'(er16); end
    endcase
    chk({"lit.model.", nm}, mv, want);
    chk({"lit.dut.", nm}, dv, want);
  endtask

  task automatic seg(input int len, input bit r, input bit v);
    for (int i = 0; i < len; i++) begin
      vr[ln] = r;
      vv[ln] = v;
      ln++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    seg(2, 1, 0);   seg(8, 0, 1);   seg(30, 0, 0);                  // single frame, t0=2
    seg(1, 1, 0);   seg(16, 0, 1);  seg(23, 0, 0);                  // back-to-back, t0=41,49
    seg(8, 0, 1);   seg(3, 0, 0);   seg(8, 0, 1);   seg(41, 0, 0);  // 3-cycle gap, t0=80,91
    seg(1, 1, 0);   seg(5, 0, 1);   seg(1, 1, 1);   seg(24, 0, 0);  // reset at t0+5, t0=141
    seg(4, 0, 1);   seg(1, 0, 0);   seg(3, 0, 1);   seg(33, 0, 0);  // drop at beat 4, t0=171
    for (int c = 0; c < LEN; c++) begin
      @(posedge clk);
      #1;
      rst = vr[c];
      in_valid = vv[c];
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      nfr[m] = 0; nxt[m] = 0; errx[m] = 0; live[m] = 0;
    end
    @(posedge clk);
    for (int c = 0; c < LEN; c++) begin
      @(negedge clk);
      cyc = c;
      for (int m = 0; m < 2; m++) if (live[m]) check_dut(m);
      case (c)
        9:   begin lit(0, "bos@9", 0, 7); lit(0, "sof@9", 3, 1); end
        12:  lit(0, "bos@12", 0, 2);
        13:  lit(0, "tw@13", 1, 'h24);
        16:  begin lit(0, "done@16", 4, 1); lit(0, "tw@16", 1, 'h30); end
        55:  lit(1, "bos3@55", 6, 0);
        56:  lit(1, "bos3@56", 6, 1);
        57:  lit(1, "bos3@57", 6, 0);
        63:  lit(0, "done@63", 4, 1);
        64:  lit(0, "busy@64", 5, 0);
        96:  lit(0, "hole@96", 2, 0);
        147: begin
          lit(0, "ov@147", 2, 0); lit(0, "busy@147", 5, 0);
          lit(1, "ov16@147", 2, 0); lit(1, "busy16@147", 5, 0);
        end
`ifdef SDF_PROTO_CHECK_EN
        176: lit(0, "err@176", 7, 1);
`else
        176: lit(0, "err@176", 7, 0);
`endif
        185: lit(0, "done@185", 4, 1);
        201: lit(1, "done16@201", 4, 1);
        default: ;
      endcase
      for (int m = 0; m < 2; m++) model_step(m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
